// File: rtl/eib_pkg.sv
// eib_pkg: shared constants and types for the vectored external interrupt block.
//   - Register offsets (addr[11:0]) inside the BASE_PAGE bus window.
//   - Bit positions in the ERR register.
//   - Decoded bus request struct handed from the decode stage to the register logic.
package eib_pkg;

    localparam logic [11:0] EIB_RA    = 12'hfff;  // write = push, read = pop
    localparam logic [11:0] EIB_ISR   = 12'hffe;  // pending status, write-1-to-clear
    localparam logic [11:0] EIB_IMR   = 12'hffd;  // mask at current nesting depth
    localparam logic [11:0] EIB_EDGE  = 12'hffc;  // 1 = edge mode, 0 = level mode
    localparam logic [11:0] EIB_VEC   = 12'hffb;  // {trap, 26'b0, vec}
    localparam logic [11:0] EIB_DEPTH = 12'hffa;  // current nesting depth
    localparam logic [11:0] EIB_ERR   = 12'hff9;  // sticky overflow/underflow

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [11:0] off;
        logic [31:0] wdata;
    } eib_req_t;

endpackage

// File: rtl/eib_prio_enc.sv
// eib_prio_enc: combinational lowest-index-first priority encoder.
//   req   in  IRQ_COUNT  request vector, bit 0 has highest priority
//   valid out 1          any request set
//   idx   out 5          index of lowest set bit (0 when valid=0)
module eib_prio_enc #(
    parameter int IRQ_COUNT = 32
) (
    input  logic [IRQ_COUNT-1:0] req,
    output logic                 valid,
    output logic [4:0]           idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (req[i]) idx = 5'(i);
        end
    end

endmodule

// File: rtl/eib_vectored.sv
// eib_vectored: vectored external interrupt block on the tenyr data bus.
//   clk, reset_n      clock, asynchronous active-low reset
//   strobe, rw, addr  bus cycle valid, 1=write, bus address
//   data              bus data, driven only on decoded reads
//   irq               external interrupt requests (synchronous to clk)
//   trap, trap_vec    registered unmasked-pending flag and its vector
// Registers live at BASE_PAGE:fxx; see eib_pkg for offsets. Nested
// mask/return-address stack gives a per-depth mask, pushed on RA write.
module eib_vectored
    import eib_pkg::*;
#(
    parameter int          IRQ_COUNT  = 32,
    parameter int          DEPTH      = 32,
    parameter logic [19:0] BASE_PAGE  = 20'hfffff,
    parameter bit          NEST_PRIO  = 1'b1,
    parameter logic [31:0] EDGE_RESET = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 strobe,
    input  logic                 rw,
    input  logic [31:0]          addr,
    inout  wire  [31:0]          data,
    input  logic [IRQ_COUNT-1:0] irq,
    output logic                 trap,
    output logic [4:0]           trap_vec
);

    localparam int            DW        = $clog2(DEPTH);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH - 1);

    eib_req_t req;
    logic     sel;

    logic [IRQ_COUNT-1:0] isr_q, isr_d, irq_q, irq_d, edge_q, edge_d, imr0_q, imr0_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic [1:0]           err_q, err_d;
    logic                 trap_q, trap_d;
    logic [4:0]           trap_vec_q, trap_vec_d;

    // Level 0 mask is reset; deeper levels are always written by a push
    // before they become current, so they stay reset-free.
    logic [IRQ_COUNT-1:0] imr_mem [DEPTH];
    logic [31:0]          rets_mem [DEPTH];

    logic                 imr_we, ret_we;
    logic [DW-1:0]        imr_waddr;
    logic [IRQ_COUNT-1:0] imr_wdata, imr_cur, set, nest_imr;
    logic [31:0]          low_mask, rd_data;
    logic                 enc_valid;
    logic [4:0]           enc_idx;

    assign sel = strobe && (addr[31:12] == BASE_PAGE);

    always_comb begin
        req.rd    = sel & ~rw;
        req.wr    = sel & rw;
        req.off   = addr[11:0];
        req.wdata = data;
    end

    assign imr_cur = (depth_q == '0) ? imr0_q : imr_mem[depth_q];

    eib_prio_enc #(.IRQ_COUNT(IRQ_COUNT)) u_enc (
        .req   (isr_q & imr_cur),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Nested mask keeps only lines strictly higher priority than the one
    // being serviced; with no trap outstanding there is nothing to inherit.
    assign low_mask = (32'd1 << trap_vec_q) - 32'd1;
    assign nest_imr = (NEST_PRIO && trap_q) ? (imr_cur & low_mask[IRQ_COUNT-1:0]) : '0;

    always_comb begin
        rd_data = '0;
        case (req.off)
            EIB_RA:    rd_data = (depth_q == '0) ? 32'd0 : rets_mem[depth_q];
            EIB_ISR:   rd_data = 32'(isr_q);
            EIB_IMR:   rd_data = 32'(imr_cur);
            EIB_EDGE:  rd_data = 32'(edge_q);
            EIB_VEC:   rd_data = {trap_q, 26'd0, trap_vec_q};
            EIB_DEPTH: rd_data = 32'(depth_q);
            EIB_ERR:   rd_data = {30'd0, err_q};
            default:   rd_data = '0;
        endcase
    end

    assign data = req.rd ? rd_data : 'z;

    always_comb begin
        isr_d      = isr_q;
        irq_d      = irq;
        edge_d     = edge_q;
        depth_d    = depth_q;
        imr0_d     = imr0_q;
        err_d      = err_q;
        imr_we     = 1'b0;
        imr_waddr  = depth_q;
        imr_wdata  = req.wdata[IRQ_COUNT-1:0];
        ret_we     = 1'b0;
        trap_d     = enc_valid;
        trap_vec_d = enc_idx;

        set = (edge_q & irq & ~irq_q) | (~edge_q & irq);
        if (req.wr && req.off == EIB_ISR) isr_d = isr_q & ~req.wdata[IRQ_COUNT-1:0];
        isr_d = isr_d | set;  // a new request beats a same-cycle clear

        if (req.wr) begin
            case (req.off)
                EIB_IMR: begin
                    if (depth_q == '0) imr0_d = req.wdata[IRQ_COUNT-1:0];
                    else               imr_we = 1'b1;
                end
                EIB_EDGE: edge_d = req.wdata[IRQ_COUNT-1:0];
                EIB_ERR:  err_d  = err_q & ~req.wdata[1:0];
                EIB_RA: begin
                    if (depth_q == DEPTH_MAX) begin
                        err_d[ERR_OVF] = 1'b1;
                    end else begin
                        depth_d   = depth_q + DW'(1);
                        imr_we    = 1'b1;
                        imr_waddr = depth_q + DW'(1);
                        imr_wdata = nest_imr;
                        ret_we    = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (req.rd && req.off == EIB_RA) begin
            if (depth_q == '0) err_d[ERR_UNF] = 1'b1;
            else               depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            isr_q      <= '0;
            irq_q      <= '0;
            edge_q     <= EDGE_RESET[IRQ_COUNT-1:0];
            depth_q    <= '0;
            imr0_q     <= '0;
            err_q      <= '0;
            trap_q     <= 1'b0;
            trap_vec_q <= '0;
        end else begin
            isr_q      <= isr_d;
            irq_q      <= irq_d;
            edge_q     <= edge_d;
            depth_q    <= depth_d;
            imr0_q     <= imr0_d;
            err_q      <= err_d;
            trap_q     <= trap_d;
            trap_vec_q <= trap_vec_d;
        end
    end

    always_ff @(posedge clk) begin
        if (imr_we) imr_mem[imr_waddr] <= imr_wdata;
        if (ret_we) rets_mem[depth_q + DW'(1)] <= req.wdata;
    end

    assign trap     = trap_q;
    assign trap_vec = trap_vec_q;

endmodule

// File: tb/tb_eib_vectored.sv
// Bench for eib_vectored: directed bus/irq sequences, a cycle-level
// behavioural model of the register file, and literal checks on key reads.
module tb_eib_vectored;

    localparam int          N  = 32;
    localparam int          D  = 8;
    localparam logic [19:0] BP = 20'hfffff;

    logic         clk = 1'b0, reset_n = 1'b1, strobe = 1'b0, rw = 1'b0;
    logic [31:0]  addr = '0, drv = '0;
    logic         drv_en = 1'b0;
    logic [N-1:0] irq = '0;
    wire  [31:0]  data;
    logic         trap;
    logic [4:0]   trap_vec;

    assign data = drv_en ? drv : 'z;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    eib_vectored #(.IRQ_COUNT(N), .DEPTH(D), .BASE_PAGE(BP), .NEST_PRIO(1'b1), .EDGE_RESET(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .rw(rw), .addr(addr),
        .data(data), .irq(irq), .trap(trap), .trap_vec(trap_vec)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_isr, m_irqp, m_edge, n_isr, pend;
    logic [31:0] m_imr [D];
    logic [31:0] m_rets [D];
    int          m_depth, m_vec, n_vec;
    logic [1:0]  m_err;
    logic        m_trap, n_trap, m_sel;
    logic [11:0] m_off;

    function automatic logic [31:0] m_read(input logic [11:0] off);
        case (off)
            12'hfff: return (m_depth == 0) ? 32'd0 : m_rets[m_depth];
            12'hffe: return m_isr;
            12'hffd: return m_imr[m_depth];
            12'hffc: return m_edge;
            12'hffb: return {m_trap, 26'd0, 5'(m_vec)};
            12'hffa: return 32'(m_depth);
            12'hff9: return {30'd0, m_err};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_isr = 0; m_irqp = 0; m_edge = 0; m_depth = 0; m_imr[0] = 0;
            m_err = 0; m_trap = 0; m_vec = 0;
        end else begin
            pend   = m_isr & m_imr[m_depth];
            n_trap = 1'b0;
            n_vec  = 0;
            for (int i = N - 1; i >= 0; i--)
                if (pend[i]) begin n_trap = 1'b1; n_vec = i; end
            m_sel = strobe && addr[31:12] == BP;
            m_off = addr[11:0];
            n_isr = m_isr;
            if (m_sel && rw && m_off == 12'hffe) n_isr = n_isr & ~drv;
            for (int i = 0; i < N; i++)
                if (m_edge[i] ? (irq[i] && !m_irqp[i]) : irq[i]) n_isr[i] = 1'b1;
            if (m_sel && rw) begin
                case (m_off)
                    12'hffd: m_imr[m_depth] = drv;
                    12'hffc: m_edge = drv;
                    12'hff9: m_err = m_err & ~drv[1:0];
                    12'hfff: begin
                        if (m_depth == D - 1) m_err[0] = 1'b1;
                        else begin
                            m_rets[m_depth+1] = drv;
                            m_imr[m_depth+1]  = m_trap ? (m_imr[m_depth] & ((32'd1 << m_vec) - 32'd1)) : 32'd0;
                            m_depth++;
                        end
                    end
                    default: ;
                endcase
            end
            if (m_sel && !rw && m_off == 12'hfff) begin
                if (m_depth == 0) m_err[1] = 1'b1;
                else              m_depth--;
            end
            m_isr  = n_isr;
            m_irqp = irq;
            m_trap = n_trap;
            m_vec  = n_vec;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("trap", 32'(trap), 32'(m_trap));
            chk("trap_vec", 32'(trap_vec), 32'(m_vec));
            if (strobe && !rw && addr[31:12] == BP)
                chk("rd_data_model", data, m_read(addr[11:0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [11:0] off, input logic [31:0] val);
        @(negedge clk); #1;
        strobe = 1'b1; rw = 1'b1; addr = {BP, off}; drv = val; drv_en = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0; rw = 1'b0; drv_en = 1'b0;
    endtask

    task automatic rd(input logic [11:0] off, input logic [31:0] exp, input string nm);
        @(negedge clk); #1;
        strobe = 1'b1; rw = 1'b0; addr = {BP, off};
        #3 chk(nm, data, exp);
        @(posedge clk); #1;
        strobe = 1'b0;
    endtask

    task automatic set_irq(input logic [N-1:0] v);
        @(negedge clk); #1 irq = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset
        #1 reset_n = 1'b0;
        #1 chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_vec", 32'(trap_vec), 32'd0);
        #11 reset_n = 1'b1;
        rd(12'hffe, 32'h0, "rst_isr");
        rd(12'hffa, 32'h0, "rst_depth");
        rd(12'hff9, 32'h0, "rst_err");
        rd(12'hffc, 32'h0, "rst_edge");

        // edge-mode irq 3
        wr(12'hffc, 32'h8);
        wr(12'hffd, 32'h8);
        set_irq(32'h8);
        set_irq(32'h0);
        @(negedge clk); #2;
        chk("edge_trap", 32'(trap), 32'd1);
        chk("edge_vec", 32'(trap_vec), 32'd3);
        rd(12'hffe, 32'h8, "edge_isr");
        wr(12'hffe, 32'h8);
        rd(12'hffe, 32'h0, "edge_isr_clr");
        @(negedge clk); #2;
        chk("edge_trap_clr", 32'(trap), 32'd0);

        // level-mode irq 5
        wr(12'hffc, 32'h0);
        wr(12'hffd, 32'h20);
        set_irq(32'h20);
        idle(2);
        wr(12'hffe, 32'h20);
        rd(12'hffe, 32'h20, "level_isr_held");
        set_irq(32'h0);
        wr(12'hffe, 32'h20);
        rd(12'hffe, 32'h0, "level_isr_clr");
        idle(2);
        chk("level_trap_clr", 32'(trap), 32'd0);

        // nesting and priority
        wr(12'hffd, 32'h84);
        set_irq(32'h80);
        idle(2);
        rd(12'hffb, 32'h8000_0007, "nest_vec7");
        wr(12'hfff, 32'h1234);
        rd(12'hffa, 32'h1, "nest_depth1");
        rd(12'hffd, 32'h4, "nest_imr1");
        set_irq(32'h84);
        idle(2);
        rd(12'hffb, 32'h8000_0002, "nest_vec2");
        rd(12'hfff, 32'h1234, "nest_pop");
        rd(12'hffa, 32'h0, "nest_depth0");
        rd(12'hffd, 32'h84, "nest_imr0");
        set_irq(32'h0);
        wr(12'hffe, 32'h84);
        rd(12'hffe, 32'h0, "nest_isr_clr");

        // overflow / underflow
        for (int i = 0; i < D; i++) wr(12'hfff, 32'h100 + 32'(i));
        rd(12'hffa, 32'(D - 1), "ovf_depth");
        rd(12'hff9, 32'h1, "ovf_err");
        for (int i = D - 2; i >= 0; i--) rd(12'hfff, 32'h100 + 32'(i), "pop_data");
        rd(12'hfff, 32'h0, "unf_data");
        rd(12'hff9, 32'h3, "unf_err");
        wr(12'hff9, 32'h3);
        rd(12'hff9, 32'h0, "err_clr");

        // simultaneous set and clear on bit 1
        wr(12'hffc, 32'h2);
        wr(12'hffd, 32'h2);
        set_irq(32'h2);
        set_irq(32'h0);
        @(negedge clk); #1;
        irq = 32'h2; strobe = 1'b1; rw = 1'b1; addr = {BP, 12'hffe}; drv = 32'h2; drv_en = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0; rw = 1'b0; drv_en = 1'b0;
        rd(12'hffe, 32'h2, "setclr_isr");
        set_irq(32'h0);
        idle(2);
        chk("setclr_trap", 32'(trap), 32'd1);

        // mid-cycle reset with trap asserted
        @(posedge clk); #2 reset_n = 1'b0;
        #1 chk("midrst_trap", 32'(trap), 32'd0);
        chk("midrst_vec", 32'(trap_vec), 32'd0);
        #4 reset_n = 1'b1;
        rd(12'hffc, 32'h0, "midrst_edge");
        rd(12'hffe, 32'h0, "midrst_isr");
        rd(12'hffa, 32'h0, "midrst_depth");

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
